debug_access_ctrl: RTL and testbench
====================================

DEBUG_ACCESS_CTRL -- requirements
Module: debug_access_ctrl

Interface
REQ-001 The block SHALL have parameter UNLOCK_KEY, default 32'hA5C3_0F1E: the key that grants debug access.
REQ-002 The block SHALL have parameter MAX_FAIL, default 3: consecutive bad keys before lockout.
REQ-003 The block SHALL have parameter LOCKOUT_CYCLES, default 256: lockout duration in clk cycles.
REQ-004 The block SHALL have parameter SESSION_CYCLES, default 1024: unlocked session length in clk cycles.
REQ-005 The block SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-006 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-007 The block SHALL have port key_valid, input, 1 bit: key submission strobe.
REQ-008 The block SHALL have port key_in, input, 32 bits: submitted key, sampled when key_valid=1.
REQ-009 The block SHALL have port lock_cmd, input, 1 bit: host request to end the session.
REQ-010 The block SHALL have port rd_req, input, 1 bit: debug read request strobe.
REQ-011 The block SHALL have port dp_data, input, 32 bits: live internal datapath register value.
REQ-012 The block SHALL have port rd_valid, output, 1 bit: read response strobe.
REQ-013 The block SHALL have port rd_data, output, 32 bits: read response data.
REQ-014 The block SHALL have port rd_err, output, 1 bit: read denied, qualified by rd_valid.
REQ-015 The block SHALL have port debug_enable, output, 1 bit: high only in the UNLOCKED state.
REQ-016 The block SHALL have port locked_out, output, 1 bit: high only in the LOCKOUT state.
REQ-017 The block SHALL have port fail_cnt, output, $clog2(MAX_FAIL+1) bits: consecutive failure count.

Function
REQ-018 The FSM SHALL have exactly four states: LOCKED, CHECK, UNLOCKED and LOCKOUT.
REQ-019 In LOCKED, key_valid=1 SHALL register key_in and move the FSM to CHECK on the next cycle.
REQ-020 CHECK SHALL last exactly one cycle, and key_valid SHALL be ignored during it.
REQ-021 In CHECK, key==UNLOCK_KEY SHALL move to UNLOCKED, clear fail_cnt and load the session timer with SESSION_CYCLES-1.
REQ-022 In CHECK, a mismatch SHALL increment fail_cnt, then move to LOCKOUT (loading the lockout timer with LOCKOUT_CYCLES-1) if the new count equals MAX_FAIL, else to LOCKED.
REQ-023 In UNLOCKED, the session timer SHALL decrement every cycle, and key_valid SHALL be ignored.
REQ-024 In UNLOCKED, lock_cmd=1 or session timer==0 SHALL move to LOCKED; if both occur in the same cycle there SHALL be one transition to LOCKED.
REQ-025 In LOCKOUT, the lockout timer SHALL decrement every cycle, and key_valid and lock_cmd SHALL be ignored.
REQ-026 In LOCKOUT, lockout timer==0 SHALL move to LOCKED and clear fail_cnt.
REQ-027 In LOCKED and CHECK, lock_cmd SHALL have no effect.
REQ-028 fail_cnt SHALL saturate at MAX_FAIL and never wrap.
REQ-029 rd_req=1 SHALL produce rd_valid=1 on the following cycle only, for a fixed latency of 1.
REQ-030 A read whose request cycle is in UNLOCKED SHALL return rd_data=dp_data sampled in that cycle with rd_err=0.
REQ-031 A read whose request cycle is in any other state SHALL return rd_data=0 with rd_err=1.
REQ-032 Back-to-back rd_req SHALL be accepted every cycle with no stall.
REQ-033 rd_data SHALL read 0 whenever rd_valid=0.
REQ-034 debug_enable and locked_out SHALL be registered state decodes with no combinational path from inputs.

Reset
REQ-035 On rst_n low, the block SHALL asynchronously enter LOCKED with fail_cnt=0, both timers=0, rd_valid=0, rd_data=0, rd_err=0, debug_enable=0 and locked_out=0.
REQ-036 Reset asserted mid-session or mid-lockout SHALL abort it, and the block SHALL leave reset in LOCKED.

Structure
REQ-037 A shared package dbg_pkg SHALL hold the state enum (dbg_state_t) and the default UNLOCK_KEY constant.
REQ-038 The session and lockout timers SHALL be a single shared down-counter, because only one is active at a time.
REQ-039 There SHALL be no sub-modules, and the block SHALL be one flat module.

Verification
REQ-040 Reset, then key_valid with 32'hA5C3_0F1E: debug_enable=1 two cycles later, and an rd_req with dp_data=32'hDEAD_BEEF returns rd_data=32'hDEAD_BEEF, rd_err=0.
REQ-041 While LOCKED, rd_req with dp_data=32'h1234_5678: rd_valid=1, rd_data=0, rd_err=1.
REQ-042 Three keys of 32'h0: fail_cnt steps 1, 2, 3, then locked_out=1 for exactly 256 cycles, a correct key during lockout is ignored, and after lockout the FSM is in LOCKED with fail_cnt=0.
REQ-043 Unlock, then leave idle: debug_enable falls exactly 1024 cycles after it rose.
REQ-044 Unlock, then assert lock_cmd in the same cycle the timer reaches 0: a single transition to LOCKED, and the next rd_req returns rd_err=1.
REQ-045 Unlock, then pulse rst_n low mid-session: all outputs read 0 immediately, and a subsequent rd_req returns rd_err=1.

Source files
------------

// File: rtl/dbg_pkg.sv
// Shared types and constants for the debug access controller.
// Holds the FSM state encoding and the default unlock key.
package dbg_pkg;

  typedef enum logic [1:0] {
    ST_LOCKED   = 2'd0,
    ST_CHECK    = 2'd1,
    ST_UNLOCKED = 2'd2,
    ST_LOCKOUT  = 2'd3
  } dbg_state_t;

  localparam logic [31:0] DBG_UNLOCK_KEY_DEFAULT = 32'hA5C3_0F1E;

endpackage

// File: rtl/debug_access_ctrl.sv
// Key-gated debug read port with failure lockout and a timed unlocked session.
// One shared down-counter times both the session and the lockout period.
module debug_access_ctrl
  import dbg_pkg::*;
#(
  parameter logic [31:0] UNLOCK_KEY     = DBG_UNLOCK_KEY_DEFAULT,
  parameter int          MAX_FAIL       = 3,
  parameter int          LOCKOUT_CYCLES = 256,
  parameter int          SESSION_CYCLES = 1024
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            key_valid,
  input  logic [31:0]                     key_in,
  input  logic                            lock_cmd,
  input  logic                            rd_req,
  input  logic [31:0]                     dp_data,
  output logic                            rd_valid,
  output logic [31:0]                     rd_data,
  output logic                            rd_err,
  output logic                            debug_enable,
  output logic                            locked_out,
  output logic [$clog2(MAX_FAIL+1)-1:0]   fail_cnt
);

  localparam int FCW     = $clog2(MAX_FAIL + 1);
  localparam int TMR_MAX = (SESSION_CYCLES > LOCKOUT_CYCLES) ? SESSION_CYCLES : LOCKOUT_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  localparam logic [FCW-1:0]   FAIL_LIMIT = FCW'(MAX_FAIL);
  localparam logic [TMR_W-1:0] SESS_LOAD  = TMR_W'(SESSION_CYCLES - 1);
  localparam logic [TMR_W-1:0] LOCK_LOAD  = TMR_W'(LOCKOUT_CYCLES - 1);

  dbg_state_t       state_q, state_d;
  logic [31:0]      key_q, key_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [FCW-1:0]   fail_cnt_q, fail_cnt_d;
  logic [FCW-1:0]   fail_inc;
  logic             rd_valid_q, rd_valid_d;
  logic [31:0]      rd_data_q, rd_data_d;
  logic             rd_err_q, rd_err_d;
  logic             debug_enable_q, debug_enable_d;
  logic             locked_out_q, locked_out_d;

  // Saturating increment so the count can never wrap past the limit.
  assign fail_inc = (fail_cnt_q == FAIL_LIMIT) ? fail_cnt_q : fail_cnt_q + FCW'(1);

  always_comb begin
    state_d    = state_q;
    key_d      = key_q;
    timer_d    = timer_q;
    fail_cnt_d = fail_cnt_q;

    case (state_q)
      ST_LOCKED: begin
        if (key_valid) begin
          key_d   = key_in;
          state_d = ST_CHECK;
        end
      end

      ST_CHECK: begin
        if (key_q == UNLOCK_KEY) begin
          fail_cnt_d = '0;
          timer_d    = SESS_LOAD;
          state_d    = ST_UNLOCKED;
        end else begin
          fail_cnt_d = fail_inc;
          if (fail_inc == FAIL_LIMIT) begin
            timer_d = LOCK_LOAD;
            state_d = ST_LOCKOUT;
          end else begin
            state_d = ST_LOCKED;
          end
        end
      end

      ST_UNLOCKED: begin
        // lock_cmd and expiry together still produce a single exit.
        if (lock_cmd || (timer_q == '0)) begin
          timer_d = '0;
          state_d = ST_LOCKED;
        end else begin
          timer_d = timer_q - TMR_W'(1);
        end
      end

      ST_LOCKOUT: begin
        if (timer_q == '0) begin
          fail_cnt_d = '0;
          state_d    = ST_LOCKED;
        end else begin
          timer_d = timer_q - TMR_W'(1);
        end
      end

      default: begin
        timer_d = '0;
        state_d = ST_LOCKED;
      end
    endcase
  end

  // Read path: permission is taken from the state in the request cycle.
  always_comb begin
    rd_valid_d = rd_req;
    rd_err_d   = rd_req && (state_q != ST_UNLOCKED);
    rd_data_d  = (rd_req && (state_q == ST_UNLOCKED)) ? dp_data : '0;
  end

  always_comb begin
    debug_enable_d = (state_d == ST_UNLOCKED);
    locked_out_d   = (state_d == ST_LOCKOUT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_LOCKED;
      key_q          <= '0;
      timer_q        <= '0;
      fail_cnt_q     <= '0;
      rd_valid_q     <= 1'b0;
      rd_data_q      <= '0;
      rd_err_q       <= 1'b0;
      debug_enable_q <= 1'b0;
      locked_out_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      key_q          <= key_d;
      timer_q        <= timer_d;
      fail_cnt_q     <= fail_cnt_d;
      rd_valid_q     <= rd_valid_d;
      rd_data_q      <= rd_data_d;
      rd_err_q       <= rd_err_d;
      debug_enable_q <= debug_enable_d;
      locked_out_q   <= locked_out_d;
    end
  end

  assign rd_valid     = rd_valid_q;
  assign rd_data      = rd_data_q;
  assign rd_err       = rd_err_q;
  assign debug_enable = debug_enable_q;
  assign locked_out   = locked_out_q;
  assign fail_cnt     = fail_cnt_q;

endmodule

// File: tb/tb_debug_access_ctrl.sv
// Bench for debug_access_ctrl: directed scenarios plus random traffic, all
// checked every cycle against a cycle-count based behavioural model.
module tb_debug_access_ctrl;

  localparam logic [31:0] KEY    = 32'hA5C3_0F1E;
  localparam int          MAXF   = 3;
  localparam int          LOCK_N = 256;
  localparam int          SESS_N = 1024;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        key_valid = 1'b0;
  logic [31:0] key_in = '0;
  logic        lock_cmd = 1'b0;
  logic        rd_req = 1'b0;
  logic [31:0] dp_data = '0;
  logic        rd_valid;
  logic [31:0] rd_data;
  logic        rd_err;
  logic        debug_enable;
  logic        locked_out;
  logic [1:0]  fail_cnt;

  debug_access_ctrl #(
    .UNLOCK_KEY    (KEY),
    .MAX_FAIL      (MAXF),
    .LOCKOUT_CYCLES(LOCK_N),
    .SESSION_CYCLES(SESS_N)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .key_valid   (key_valid),
    .key_in      (key_in),
    .lock_cmd    (lock_cmd),
    .rd_req      (rd_req),
    .dp_data     (dp_data),
    .rd_valid    (rd_valid),
    .rd_data     (rd_data),
    .rd_err      (rd_err),
    .debug_enable(debug_enable),
    .locked_out  (locked_out),
    .fail_cnt    (fail_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: mode 0=locked 1=check 2=unlocked 3=lockout; timed states leave
  // when the absolute cycle number reaches m_last.
  int          m_mode = 0;
  int          m_fail = 0;
  int          mc = 0;
  int          m_last = 0;
  logic [31:0] m_key = '0;
  logic        m_rv = 1'b0;
  logic        m_re = 1'b0;
  logic [31:0] m_rd = '0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_mode = 0; m_fail = 0; mc = 0; m_rv = 1'b0; m_re = 1'b0; m_rd = '0;
    end else begin
      m_rv = rd_req;
      m_re = rd_req && (m_mode != 2);
      m_rd = (rd_req && (m_mode == 2)) ? dp_data : 32'h0;
      case (m_mode)
        0: if (key_valid) begin m_key = key_in; m_mode = 1; end
        1: begin
          if (m_key == KEY) begin
            m_mode = 2; m_fail = 0; m_last = mc + SESS_N;
          end else begin
            if (m_fail < MAXF) m_fail = m_fail + 1;
            if (m_fail == MAXF) begin m_mode = 3; m_last = mc + LOCK_N; end
            else m_mode = 0;
          end
        end
        2: if (lock_cmd || (mc == m_last)) m_mode = 0;
        default: if (mc == m_last) begin m_mode = 0; m_fail = 0; end
      endcase
      mc++;
    end
    #1;
    chk("model_rd_valid", 32'(rd_valid), 32'(m_rv));
    chk("model_rd_data", rd_data, m_rd);
    chk("model_rd_err", 32'(rd_err), 32'(m_re));
    chk("model_debug_enable", 32'(debug_enable), 32'(m_mode == 2));
    chk("model_locked_out", 32'(locked_out), 32'(m_mode == 3));
    chk("model_fail_cnt", 32'(fail_cnt), 32'(m_fail));
  end

  task automatic drive(input logic kv, input logic [31:0] k, input logic lc,
                       input logic rr, input logic [31:0] dp);
    key_valid = kv; key_in = k; lock_cmd = lc; rd_req = rr; dp_data = dp;
    @(negedge clk);
  endtask

  task automatic idle();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rd_valid"}, 32'(rd_valid), 32'h0);
    chk({tag, "_rd_data"}, rd_data, 32'h0);
    chk({tag, "_rd_err"}, 32'(rd_err), 32'h0);
    chk({tag, "_debug_enable"}, 32'(debug_enable), 32'h0);
    chk({tag, "_locked_out"}, 32'(locked_out), 32'h0);
    chk({tag, "_fail_cnt"}, 32'(fail_cnt), 32'h0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    logic kv, lc, rr;
    logic [31:0] k;

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;
    idle();

    // Read while locked is denied.
    drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h1234_5678);
    chk("locked_rd_valid", 32'(rd_valid), 32'h1);
    chk("locked_rd_data", rd_data, 32'h0);
    chk("locked_rd_err", 32'(rd_err), 32'h1);

    // Correct key: enable two cycles after submission, then the session length.
    drive(1'b1, KEY, 1'b0, 1'b0, 32'h0);
    chk("check_cycle_de", 32'(debug_enable), 32'h0);
    idle();
    chk("unlock_de", 32'(debug_enable), 32'h1);
    drive(1'b0, 32'h0, 1'b0, 1'b1, 32'hDEAD_BEEF);
    chk("unlocked_rd_data", rd_data, 32'hDEAD_BEEF);
    chk("unlocked_rd_err", 32'(rd_err), 32'h0);
    cnt = 2;
    for (int i = 0; i < 2000 && debug_enable; i++) begin
      idle();
      if (debug_enable) cnt++;
    end
    chk("session_len", 32'(cnt), 32'd1024);

    // Three bad keys lead to a 256-cycle lockout that ignores a good key.
    for (int i = 1; i <= 3; i++) begin
      drive(1'b1, 32'h0, 1'b0, 1'b0, 32'h0);
      idle();
      chk("fail_step", 32'(fail_cnt), 32'(i));
    end
    chk("lockout_entered", 32'(locked_out), 32'h1);
    cnt = 1;
    for (int i = 0; i < 400 && locked_out; i++) begin
      if (i == 100) drive(1'b1, KEY, 1'b1, 1'b0, 32'h0);
      else idle();
      if (locked_out) cnt++;
    end
    chk("lockout_len", 32'(cnt), 32'd256);
    chk("lockout_fail_clr", 32'(fail_cnt), 32'h0);
    chk("lockout_no_unlock", 32'(debug_enable), 32'h0);
    idle();
    chk("after_lockout_de", 32'(debug_enable), 32'h0);

    // lock_cmd in the same cycle the session timer expires.
    drive(1'b1, KEY, 1'b0, 1'b0, 32'h0);
    idle();
    chk("relock_unlock_de", 32'(debug_enable), 32'h1);
    repeat (1023) idle();
    chk("last_cycle_de", 32'(debug_enable), 32'h1);
    drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    chk("coincide_de", 32'(debug_enable), 32'h0);
    idle();
    chk("coincide_de2", 32'(debug_enable), 32'h0);
    drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h0BAD_0BAD);
    chk("coincide_rd_err", 32'(rd_err), 32'h1);
    drive(1'b1, KEY, 1'b0, 1'b0, 32'h0);
    idle();
    chk("reunlock_de", 32'(debug_enable), 32'h1);

    // Asynchronous reset mid-session.
    repeat (10) idle();
    drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h5555_AAAA);
    chk("pre_reset_rd_data", rd_data, 32'h5555_AAAA);
    rd_req = 1'b0;
    #2 rst_n = 1'b0;
    #1 chk_all_zero("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    idle();
    drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h7777_8888);
    chk("post_reset_rd_err", 32'(rd_err), 32'h1);
    chk("post_reset_rd_data", rd_data, 32'h0);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      kv = ($urandom % 4) == 0;
      k  = (($urandom % 3) == 0) ? KEY : $urandom;
      lc = ($urandom % 32) == 0;
      rr = $urandom % 2;
      drive(kv, k, lc, rr, $urandom);
    end
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
